// File: rtl/reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared types and constants for the reset sequencer:
//   state_t   - FSM state encoding (ASSERT=0 .. FAULT=5), also exported on
//               state_dbg
//   STATE_W   - width of state_t / state_dbg
//   DEF_*     - default parameter values for the sequencer and its interface
//   max3()    - elaboration-time helper used to size the shared counter
// Optional feature macro (used by reset_sequencer): RESET_SEQ_LOCK_TIMEOUT_EN
// -----------------------------------------------------------------------------
package reset_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STRETCH   = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  localparam int DEF_NUM_CHANNELS   = 4;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_STRETCH_CYCLES = 16;
  localparam int DEF_STEP_CYCLES    = 8;
  localparam int DEF_LOCK_TIMEOUT   = 1024;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
// Bundles the sequencer's status/control signals.
//   pll_lock     - PLL lock, asynchronous to clk (into the sequencer)
//   sw_reset_req - synchronous one-cycle request to re-run the sequence
//   rst_out      - active-high per-domain resets, bit 0 released first
//   all_ready    - high while every channel is released
//   idle         - high whenever the sequencer is not in RUN
//   lock_fault   - PLL lock timeout flag
//   state_dbg    - current FSM state encoding
// Modports: master = the sequencer, slave = consumers / board-level driver.
// -----------------------------------------------------------------------------
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS
);

  logic                    pll_lock;
  logic                    sw_reset_req;
  logic [NUM_CHANNELS-1:0] rst_out;
  logic                    all_ready;
  logic                    idle;
  logic                    lock_fault;
  logic [STATE_W-1:0]      state_dbg;

  modport master (
    input  pll_lock,
    input  sw_reset_req,
    output rst_out,
    output all_ready,
    output idle,
    output lock_fault,
    output state_dbg
  );

  modport slave (
    output pll_lock,
    output sw_reset_req,
    input  rst_out,
    input  all_ready,
    input  idle,
    input  lock_fault,
    input  state_dbg
  );

endinterface

// File: rtl/reset_sequencer_sync_bit.sv
// -----------------------------------------------------------------------------
// sync_bit
// Parametrised-depth flop chain bringing a single bit into the clk domain.
// The whole chain clears asynchronously while n_clr is low.
//   clk    - destination clock
//   n_clr  - asynchronous active-low clear
//   d      - asynchronous input bit
//   q      - synchronised output (STAGES clk edges after d changes)
// -----------------------------------------------------------------------------
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic n_clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Reset and bring-up controller: synchronises the board reset release, waits
// for PLL lock, stretches reset, then releases NUM_CHANNELS reset domains one
// at a time (bit 0 first) every STEP_CYCLES cycles.
//   clk     - system clock (PLL output)
//   N_RESET - board reset, asynchronous assert, active low
//   bus     - reset_sequencer_if.master: pll_lock, sw_reset_req in;
//             rst_out, all_ready, idle, lock_fault, state_dbg out
// Optional feature: define RESET_SEQ_LOCK_TIMEOUT_EN to bound WAIT_LOCK to
// LOCK_TIMEOUT cycles and enter FAULT (lock_fault=1) on expiry. Without it
// WAIT_LOCK waits indefinitely and lock_fault is constant 0.
// -----------------------------------------------------------------------------
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CHANNELS   = DEF_NUM_CHANNELS,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int STEP_CYCLES    = DEF_STEP_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT
) (
  input  logic              clk,
  input  logic              N_RESET,
  reset_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(max3(STRETCH_CYCLES, STEP_CYCLES, LOCK_TIMEOUT) + 1);
  localparam int CH_W  = $clog2(NUM_CHANNELS) + 1;

  logic rst_sync_n;
  logic lock_s;

  // Release of N_RESET is synchronised; assertion passes straight through the
  // chain's async clear, so rst_sync_n falls with N_RESET and every register
  // below (including rst_out) is forced to its reset value without a clock.
  sync_bit #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk   (clk),
    .n_clr (N_RESET),
    .d     (1'b1),
    .q     (rst_sync_n)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .n_clr (N_RESET),
    .d     (bus.pll_lock),
    .q     (lock_s)
  );

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [CH_W-1:0]         ch_reg;
  logic [NUM_CHANNELS-1:0] rst_out_reg;
  logic                    all_ready_reg;
  logic                    idle_reg;
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
  logic                    lock_fault_reg;
`endif

  // Restart to WAIT_LOCK: a software request wins over everything else in any
  // state but ASSERT (FAULT's only exit is this same request), and losing lock
  // once the stretch has begun abandons the sequence. Lock loss during RELEASE
  // is treated like RUN so a partially released system never runs unlocked.
  logic restart;

  always_comb begin
    restart = 1'b0;
    if (bus.sw_reset_req && (state_reg != ST_ASSERT)) begin
      restart = 1'b1;
    end else if (!lock_s && ((state_reg == ST_STRETCH) ||
                             (state_reg == ST_RELEASE) ||
                             (state_reg == ST_RUN))) begin
      restart = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_reg      <= ST_ASSERT;
      cnt_reg        <= '0;
      ch_reg         <= '0;
      rst_out_reg    <= '1;
      all_ready_reg  <= 1'b0;
      idle_reg       <= 1'b1;
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
      lock_fault_reg <= 1'b0;
`endif
    end else if (restart) begin
      state_reg      <= ST_WAIT_LOCK;
      cnt_reg        <= '0;
      ch_reg         <= '0;
      rst_out_reg    <= '1;
      all_ready_reg  <= 1'b0;
      idle_reg       <= 1'b1;
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
      lock_fault_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_ASSERT: begin
          state_reg <= ST_WAIT_LOCK;
          cnt_reg   <= '0;
        end

        ST_WAIT_LOCK: begin
          rst_out_reg <= '1;
          if (lock_s) begin
            state_reg <= ST_STRETCH;
            cnt_reg   <= '0;
          end
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
          else if (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1)) begin
            state_reg      <= ST_FAULT;
            lock_fault_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
`endif
        end

        ST_STRETCH: begin
          if (cnt_reg == CNT_W'(STRETCH_CYCLES - 1)) begin
            // Bit 0 drops on the same edge that leaves STRETCH.
            cnt_reg        <= '0;
            ch_reg         <= '0;
            rst_out_reg[0] <= 1'b0;
            if (NUM_CHANNELS == 1) begin
              state_reg     <= ST_RUN;
              all_ready_reg <= 1'b1;
              idle_reg      <= 1'b0;
            end else begin
              state_reg <= ST_RELEASE;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (cnt_reg == CNT_W'(STEP_CYCLES - 1)) begin
            cnt_reg <= '0;
            ch_reg  <= ch_reg + CH_W'(1);
            for (int i = 1; i < NUM_CHANNELS; i++) begin
              if (i == int'(ch_reg) + 1) begin
                rst_out_reg[i] <= 1'b0;
              end
            end
            if (ch_reg + CH_W'(1) == CH_W'(NUM_CHANNELS - 1)) begin
              state_reg     <= ST_RUN;
              all_ready_reg <= 1'b1;
              idle_reg      <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        ST_RUN: begin
          state_reg <= ST_RUN;
        end

        default: begin
          // FAULT holds all domains in reset until a software request.
          rst_out_reg   <= '1;
          all_ready_reg <= 1'b0;
          idle_reg      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rst_out    = rst_out_reg;
  assign bus.all_ready  = all_ready_reg;
  assign bus.idle       = idle_reg;
  assign bus.state_dbg  = state_reg;
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
  assign bus.lock_fault = lock_fault_reg;
`else
  assign bus.lock_fault = 1'b0;
`endif

endmodule
